// File: rtl/pipelined_control_unit.sv
// RV32I decode into the control half of the ID/EX register, with load-use
// hazard detection, flush/hold handling and a saturating illegal-instruction count.
module pipelined_control_unit #(
  parameter int ALU_OP_WIDTH  = 4,
  parameter int ILL_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_i,
  input  logic [31:0]              instr_i,
  input  logic                     flush_i,
  input  logic                     hold_i,
  output logic                     stall_o,
  output logic                     ex_valid_o,
  output logic                     ex_reg_write_o,
  output logic [1:0]               ex_wb_sel_o,
  output logic                     ex_mem_read_o,
  output logic                     ex_mem_write_o,
  output logic                     ex_branch_o,
  output logic                     ex_jump_o,
  output logic                     ex_jalr_o,
  output logic                     ex_alu_src_o,
  output logic                     ex_alu_a_pc_o,
  output logic [ALU_OP_WIDTH-1:0]  ex_alu_op_o,
  output logic [2:0]               ex_funct3_o,
  output logic [4:0]               ex_rd_o,
  output logic [4:0]               ex_rs1_o,
  output logic [4:0]               ex_rs2_o,
  output logic                     ex_illegal_o,
  output logic [ILL_CNT_WIDTH-1:0] ill_count_o
);

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_AND    = 4'd2;
  localparam logic [3:0] ALU_OR     = 4'd3;
  localparam logic [3:0] ALU_XOR    = 4'd4;
  localparam logic [3:0] ALU_SLT    = 4'd5;
  localparam logic [3:0] ALU_SLTU   = 4'd6;
  localparam logic [3:0] ALU_SLL    = 4'd7;
  localparam logic [3:0] ALU_SRL    = 4'd8;
  localparam logic [3:0] ALU_SRA    = 4'd9;
  localparam logic [3:0] ALU_COPY_B = 4'd11;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  typedef struct packed {
    logic                    valid;
    logic                    reg_write;
    logic [1:0]              wb_sel;
    logic                    mem_read;
    logic                    mem_write;
    logic                    branch;
    logic                    jump;
    logic                    jalr;
    logic                    alu_src;
    logic                    alu_a_pc;
    logic [ALU_OP_WIDTH-1:0] alu_op;
    logic [2:0]              funct3;
    logic [4:0]              rd;
    logic [4:0]              rs1;
    logic [4:0]              rs2;
    logic                    illegal;
  } ex_bundle_t;

  function automatic logic [ALU_OP_WIDTH-1:0] alu(input logic [3:0] code);
    return ALU_OP_WIDTH'(code);
  endfunction

  ex_bundle_t               w_dec;
  ex_bundle_t               r_ex;
  logic [6:0]               w_opcode;
  logic [2:0]               w_funct3;
  logic [6:0]               w_funct7;
  logic                     w_rs1_used;
  logic                     w_rs2_used;
  logic                     w_load_use;
  logic [ILL_CNT_WIDTH-1:0] r_ill_count;

  assign w_opcode = instr_i[6:0];
  assign w_funct3 = instr_i[14:12];
  assign w_funct7 = instr_i[31:25];

  always_comb begin
    w_dec        = '0;
    w_rs1_used   = 1'b0;
    w_rs2_used   = 1'b0;
    w_dec.valid  = 1'b1;
    w_dec.funct3 = w_funct3;
    w_dec.rd     = instr_i[11:7];
    w_dec.rs1    = instr_i[19:15];
    w_dec.rs2    = instr_i[24:20];
    w_dec.alu_op = alu(ALU_ADD);
    case (w_opcode)
      OP_REG: begin
        w_dec.reg_write = 1'b1;
        w_rs1_used      = 1'b1;
        w_rs2_used      = 1'b1;
        if (w_funct7 == 7'b0000000) begin
          case (w_funct3)
            3'b000:  w_dec.alu_op = alu(ALU_ADD);
            3'b001:  w_dec.alu_op = alu(ALU_SLL);
            3'b010:  w_dec.alu_op = alu(ALU_SLT);
            3'b011:  w_dec.alu_op = alu(ALU_SLTU);
            3'b100:  w_dec.alu_op = alu(ALU_XOR);
            3'b101:  w_dec.alu_op = alu(ALU_SRL);
            3'b110:  w_dec.alu_op = alu(ALU_OR);
            default: w_dec.alu_op = alu(ALU_AND);
          endcase
        end else if (w_funct7 == 7'b0100000 && w_funct3 == 3'b000) begin
          w_dec.alu_op = alu(ALU_SUB);
        end else if (w_funct7 == 7'b0100000 && w_funct3 == 3'b101) begin
          w_dec.alu_op = alu(ALU_SRA);
        end else begin
          w_dec.illegal = 1'b1;
        end
      end
      OP_IMM: begin
        w_dec.reg_write = 1'b1;
        w_dec.alu_src   = 1'b1;
        w_rs1_used      = 1'b1;
        case (w_funct3)
          3'b000: w_dec.alu_op = alu(ALU_ADD);
          3'b001: begin
            w_dec.alu_op = alu(ALU_SLL);
            if (w_funct7 != 7'b0000000) w_dec.illegal = 1'b1;
          end
          3'b010: w_dec.alu_op = alu(ALU_SLT);
          3'b011: w_dec.alu_op = alu(ALU_SLTU);
          3'b100: w_dec.alu_op = alu(ALU_XOR);
          3'b101: begin
            w_dec.alu_op = instr_i[30] ? alu(ALU_SRA) : alu(ALU_SRL);
            if (w_funct7 != 7'b0000000 && w_funct7 != 7'b0100000) w_dec.illegal = 1'b1;
          end
          3'b110:  w_dec.alu_op = alu(ALU_OR);
          default: w_dec.alu_op = alu(ALU_AND);
        endcase
      end
      OP_LOAD: begin
        w_dec.reg_write = 1'b1;
        w_dec.alu_src   = 1'b1;
        w_dec.mem_read  = 1'b1;
        w_dec.wb_sel    = WB_MEM;
        w_rs1_used      = 1'b1;
        if (w_funct3 == 3'b011 || w_funct3[2:1] == 2'b11) w_dec.illegal = 1'b1;
      end
      OP_STORE: begin
        w_dec.alu_src   = 1'b1;
        w_dec.mem_write = 1'b1;
        w_rs1_used      = 1'b1;
        w_rs2_used      = 1'b1;
        if (w_funct3 >= 3'b011) w_dec.illegal = 1'b1;
      end
      OP_BRANCH: begin
        w_dec.branch = 1'b1;
        w_dec.alu_op = alu(ALU_SUB);
        w_rs1_used   = 1'b1;
        w_rs2_used   = 1'b1;
        if (w_funct3[2:1] == 2'b01) w_dec.illegal = 1'b1;
      end
      OP_LUI: begin
        w_dec.reg_write = 1'b1;
        w_dec.alu_src   = 1'b1;
        w_dec.alu_op    = alu(ALU_COPY_B);
      end
      OP_AUIPC: begin
        w_dec.reg_write = 1'b1;
        w_dec.alu_src   = 1'b1;
        w_dec.alu_a_pc  = 1'b1;
      end
      OP_JAL: begin
        w_dec.reg_write = 1'b1;
        w_dec.jump      = 1'b1;
        w_dec.wb_sel    = WB_PC4;
      end
      OP_JALR: begin
        w_dec.reg_write = 1'b1;
        w_dec.jump      = 1'b1;
        w_dec.jalr      = 1'b1;
        w_dec.alu_src   = 1'b1;
        w_dec.wb_sel    = WB_PC4;
        w_rs1_used      = 1'b1;
        if (w_funct3 != 3'b000) w_dec.illegal = 1'b1;
      end
      default: w_dec.illegal = 1'b1;
    endcase
    // An illegal word keeps its register fields for trap reporting but does nothing.
    if (w_dec.illegal) begin
      w_dec.reg_write = 1'b0;
      w_dec.wb_sel    = WB_ALU;
      w_dec.mem_read  = 1'b0;
      w_dec.mem_write = 1'b0;
      w_dec.branch    = 1'b0;
      w_dec.jump      = 1'b0;
      w_dec.jalr      = 1'b0;
      w_dec.alu_src   = 1'b0;
      w_dec.alu_a_pc  = 1'b0;
      w_dec.alu_op    = alu(ALU_ADD);
    end
  end

  assign w_load_use = valid_i & r_ex.valid & r_ex.mem_read & (r_ex.rd != 5'd0) &
                      ((w_rs1_used & (instr_i[19:15] == r_ex.rd)) |
                       (w_rs2_used & (instr_i[24:20] == r_ex.rd)));

  assign stall_o = ~rst & ~flush_i & (hold_i | w_load_use);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex        <= '0;
      r_ill_count <= '0;
    end else if (flush_i) begin
      r_ex <= '0;
    end else if (hold_i) begin
      r_ex <= r_ex;
    end else if (w_load_use) begin
      r_ex <= '0;
    end else if (valid_i) begin
      r_ex <= w_dec;
      if (w_dec.illegal && (r_ill_count != '1))
        r_ill_count <= r_ill_count + ILL_CNT_WIDTH'(1);
    end else begin
      r_ex <= '0;
    end
  end

  assign ex_valid_o     = r_ex.valid;
  assign ex_reg_write_o = r_ex.reg_write;
  assign ex_wb_sel_o    = r_ex.wb_sel;
  assign ex_mem_read_o  = r_ex.mem_read;
  assign ex_mem_write_o = r_ex.mem_write;
  assign ex_branch_o    = r_ex.branch;
  assign ex_jump_o      = r_ex.jump;
  assign ex_jalr_o      = r_ex.jalr;
  assign ex_alu_src_o   = r_ex.alu_src;
  assign ex_alu_a_pc_o  = r_ex.alu_a_pc;
  assign ex_alu_op_o    = r_ex.alu_op;
  assign ex_funct3_o    = r_ex.funct3;
  assign ex_rd_o        = r_ex.rd;
  assign ex_rs1_o       = r_ex.rs1;
  assign ex_rs2_o       = r_ex.rs2;
  assign ex_illegal_o   = r_ex.illegal;
  assign ill_count_o    = r_ill_count;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Bench for pipelined_control_unit: decode vector table plus hand-written
// hazard, flush, hold and counter-saturation sequences, checked via a scoreboard.
module tb_pipelined_control_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [31:0] instr_i;
  logic        flush_i;
  logic        hold_i;
  logic        stall_o;
  logic        ex_valid_o, ex_reg_write_o, ex_mem_read_o, ex_mem_write_o;
  logic [1:0]  ex_wb_sel_o;
  logic        ex_branch_o, ex_jump_o, ex_jalr_o, ex_alu_src_o, ex_alu_a_pc_o;
  logic [3:0]  ex_alu_op_o;
  logic [2:0]  ex_funct3_o;
  logic [4:0]  ex_rd_o, ex_rs1_o, ex_rs2_o;
  logic        ex_illegal_o;
  logic [7:0]  ill_count_o;

  always #5 clk = ~clk;

  pipelined_control_unit #(.ALU_OP_WIDTH(4), .ILL_CNT_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .instr_i(instr_i),
    .flush_i(flush_i), .hold_i(hold_i), .stall_o(stall_o),
    .ex_valid_o(ex_valid_o), .ex_reg_write_o(ex_reg_write_o), .ex_wb_sel_o(ex_wb_sel_o),
    .ex_mem_read_o(ex_mem_read_o), .ex_mem_write_o(ex_mem_write_o),
    .ex_branch_o(ex_branch_o), .ex_jump_o(ex_jump_o), .ex_jalr_o(ex_jalr_o),
    .ex_alu_src_o(ex_alu_src_o), .ex_alu_a_pc_o(ex_alu_a_pc_o), .ex_alu_op_o(ex_alu_op_o),
    .ex_funct3_o(ex_funct3_o), .ex_rd_o(ex_rd_o), .ex_rs1_o(ex_rs1_o), .ex_rs2_o(ex_rs2_o),
    .ex_illegal_o(ex_illegal_o), .ill_count_o(ill_count_o)
  );

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       jalr;
    logic       alu_src;
    logic       alu_a_pc;
    logic [3:0] alu_op;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       illegal;
  } ex_t;

  typedef struct {
    ex_t exp;
    ex_t care;
  } sb_t;

  typedef struct {
    logic [31:0] instr;
    sb_t         e;
  } vec_t;

  localparam logic [6:0] OP_REG = 7'b0110011, OP_IMM = 7'b0010011, OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011, OP_BR = 7'b1100011, OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111, OP_JALR = 7'b1100111;

  ex_t  act;
  sb_t  sb[$];
  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;
  int   cnt_m  = 0;

  assign act = {ex_valid_o, ex_reg_write_o, ex_wb_sel_o, ex_mem_read_o, ex_mem_write_o,
                ex_branch_o, ex_jump_o, ex_jalr_o, ex_alu_src_o, ex_alu_a_pc_o,
                ex_alu_op_o, ex_funct3_o, ex_rd_o, ex_rs1_o, ex_rs2_o, ex_illegal_o};

  function automatic logic [31:0] enc(input logic [6:0] f7, input logic [4:0] r2,
                                      input logic [4:0] r1, input logic [2:0] f3,
                                      input logic [4:0] rd, input logic [6:0] op);
    return {f7, r2, r1, f3, rd, op};
  endfunction

  // fm selects which register/funct3 fields are meaningful: {funct3, rd, rs1, rs2}
  function automatic sb_t mk(input logic [31:0] ins, input logic rw, input logic [1:0] wb,
                             input logic mr, input logic mw, input logic br, input logic j,
                             input logic jr, input logic asrc, input logic apc,
                             input logic [3:0] op, input logic ill, input logic aluc,
                             input logic [3:0] fm);
    sb_t s;
    s.exp           = '0;
    s.care          = '1;
    s.exp.valid     = 1'b1;
    s.exp.reg_write = rw;
    s.exp.wb_sel    = wb;
    s.exp.mem_read  = mr;
    s.exp.mem_write = mw;
    s.exp.branch    = br;
    s.exp.jump      = j;
    s.exp.jalr      = jr;
    s.exp.alu_src   = asrc;
    s.exp.alu_a_pc  = apc;
    s.exp.alu_op    = op;
    s.exp.illegal   = ill;
    s.exp.funct3    = ins[14:12];
    s.exp.rd        = ins[11:7];
    s.exp.rs1       = ins[19:15];
    s.exp.rs2       = ins[24:20];
    if (!aluc) begin
      s.care.alu_op   = '0;
      s.care.alu_src  = 1'b0;
      s.care.alu_a_pc = 1'b0;
    end
    if (!fm[3]) s.care.funct3 = '0;
    if (!fm[2]) s.care.rd = '0;
    if (!fm[1]) s.care.rs1 = '0;
    if (!fm[0]) s.care.rs2 = '0;
    return s;
  endfunction

  function automatic sb_t bubble();
    sb_t s;
    s.exp  = '0;
    s.care = '1;
    return s;
  endfunction

  function automatic sb_t ill_e(input logic [31:0] ins);
    return mk(ins, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 4'd0, 1, 0, 4'b0000);
  endfunction

  task automatic av(input logic [31:0] ins, input sb_t e);
    vec_t v;
    v.instr = ins;
    v.e     = e;
    vecs.push_back(v);
  endtask

  task automatic chk_bit(input string nm, input logic a, input logic x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s got=%b want=%b", nm, a, x);
    end
  endtask

  task automatic chk_cnt(input string nm, input int x);
    checks++;
    if (ill_count_o !== 8'(x)) begin
      errors++;
      $display("FAIL %s ill_count got=%0d want=%0d", nm, ill_count_o, x);
    end
  endtask

  task automatic chk_ex(input string nm);
    sb_t e;
    logic [$bits(ex_t)-1:0] d;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s no expectation queued", nm);
    end else begin
      e = sb.pop_front();
      d = (act ^ e.exp) & e.care;
      if (d != '0 || $isunknown(act & e.care)) begin
        errors++;
        $display("FAIL %s ex got=%h want=%h care=%h", nm, act, e.exp, e.care);
      end
    end
  endtask

  // Drive on the falling edge, check stall combinationally, check EX after the next rise.
  task automatic step(input logic [31:0] ins, input logic v, input logic fl, input logic hd,
                      input logic exp_stall, input sb_t e, input string nm);
    instr_i = ins;
    valid_i = v;
    flush_i = fl;
    hold_i  = hd;
    #1;
    chk_bit({nm, "_stall"}, stall_o, exp_stall);
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    chk_ex(nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [31:0] i_add3, i_lw5, i_add65, i_add625, i_lw0, i_add60, i_sub7, i_jal, i_lui5, i_ffff;
    sb_t e_add3, e_lw5, e_add65, e_sub7;

    i_add3   = 32'h002081B3;
    i_lw5    = enc(7'h00, 5'd0, 5'd1, 3'b010, 5'd5, OP_LOAD);
    i_add65  = enc(7'h00, 5'd2, 5'd5, 3'b000, 5'd6, OP_REG);
    i_add625 = enc(7'h00, 5'd5, 5'd2, 3'b000, 5'd6, OP_REG);
    i_lw0    = enc(7'h00, 5'd0, 5'd1, 3'b010, 5'd0, OP_LOAD);
    i_add60  = enc(7'h00, 5'd2, 5'd0, 3'b000, 5'd6, OP_REG);
    i_sub7   = enc(7'h20, 5'd2, 5'd1, 3'b000, 5'd7, OP_REG);
    i_jal    = 32'h008000EF;
    i_lui5   = enc(7'h12, 5'd3, 5'd5, 3'b010, 5'd10, OP_LUI);
    i_ffff   = 32'hFFFFFFFF;

    e_add3  = mk(i_add3, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 4'd0, 0, 1, 4'b1111);
    e_lw5   = mk(i_lw5, 1, 2'b01, 1, 0, 0, 0, 0, 1, 0, 4'd0, 0, 1, 4'b1110);
    e_add65 = mk(i_add65, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 4'd0, 0, 1, 4'b1111);
    e_sub7  = mk(i_sub7, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 4'd1, 0, 1, 4'b1111);

    // Decode table: one legal instruction per class/op plus each illegal pattern.
    av(i_add3, e_add3);
    av(i_sub7, e_sub7);
    for (int k = 0; k < 8; k++) begin
      logic [3:0] rops [8];
      logic [3:0] iops [8];
      logic [31:0] w;
      rops = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd3, 4'd2};
      iops = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd3, 4'd2};
      w = enc(7'h00, 5'd2, 5'd1, 3'(k), 5'd3, OP_REG);
      av(w, mk(w, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, rops[k], 0, 1, 4'b1111));
      w = enc((k == 1 || k == 5) ? 7'h00 : 7'h7F, 5'd17, 5'd1, 3'(k), 5'd4, OP_IMM);
      av(w, mk(w, 1, 2'b00, 0, 0, 0, 0, 0, 1, 0, iops[k], 0, 1, 4'b1110));
    end
    av(enc(7'h20, 5'd2, 5'd1, 3'b101, 5'd3, OP_REG),
       mk(enc(7'h20, 5'd2, 5'd1, 3'b101, 5'd3, OP_REG), 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 4'd9, 0, 1, 4'b1111));
    av(enc(7'h20, 5'd3, 5'd1, 3'b101, 5'd4, OP_IMM),
       mk(enc(7'h20, 5'd3, 5'd1, 3'b101, 5'd4, OP_IMM), 1, 2'b00, 0, 0, 0, 0, 0, 1, 0, 4'd9, 0, 1, 4'b1110));
    av(i_lw5, e_lw5);
    av(enc(7'h00, 5'd4, 5'd1, 3'b101, 5'd9, OP_LOAD),
       mk(enc(7'h00, 5'd4, 5'd1, 3'b101, 5'd9, OP_LOAD), 1, 2'b01, 1, 0, 0, 0, 0, 1, 0, 4'd0, 0, 1, 4'b1110));
    av(enc(7'h00, 5'd2, 5'd1, 3'b010, 5'd8, OP_STORE),
       mk(enc(7'h00, 5'd2, 5'd1, 3'b010, 5'd8, OP_STORE), 0, 2'b00, 0, 1, 0, 0, 0, 1, 0, 4'd0, 0, 1, 4'b1011));
    av(enc(7'h00, 5'd2, 5'd1, 3'b000, 5'd8, OP_BR),
       mk(enc(7'h00, 5'd2, 5'd1, 3'b000, 5'd8, OP_BR), 0, 2'b00, 0, 0, 1, 0, 0, 0, 0, 4'd1, 0, 1, 4'b1011));
    av(enc(7'h00, 5'd2, 5'd1, 3'b111, 5'd8, OP_BR),
       mk(enc(7'h00, 5'd2, 5'd1, 3'b111, 5'd8, OP_BR), 0, 2'b00, 0, 0, 1, 0, 0, 0, 0, 4'd1, 0, 1, 4'b1011));
    av(i_lui5, mk(i_lui5, 1, 2'b00, 0, 0, 0, 0, 0, 1, 0, 4'd11, 0, 1, 4'b0100));
    av(enc(7'h12, 5'd3, 5'd5, 3'b010, 5'd11, OP_AUIPC),
       mk(enc(7'h12, 5'd3, 5'd5, 3'b010, 5'd11, OP_AUIPC), 1, 2'b00, 0, 0, 0, 0, 0, 1, 1, 4'd0, 0, 1, 4'b0100));
    av(i_jal, mk(i_jal, 1, 2'b10, 0, 0, 0, 1, 0, 0, 0, 4'd0, 0, 0, 4'b0100));
    av(enc(7'h00, 5'd4, 5'd1, 3'b000, 5'd1, OP_JALR),
       mk(enc(7'h00, 5'd4, 5'd1, 3'b000, 5'd1, OP_JALR), 1, 2'b10, 0, 0, 0, 1, 1, 1, 0, 4'd0, 0, 1, 4'b1110));
    av(i_ffff, ill_e(i_ffff));
    av(enc(7'h01, 5'd2, 5'd1, 3'b000, 5'd3, OP_REG), ill_e(enc(7'h01, 5'd2, 5'd1, 3'b000, 5'd3, OP_REG)));
    av(enc(7'h20, 5'd2, 5'd1, 3'b001, 5'd3, OP_REG), ill_e(enc(7'h20, 5'd2, 5'd1, 3'b001, 5'd3, OP_REG)));
    av(enc(7'h20, 5'd2, 5'd1, 3'b001, 5'd3, OP_IMM), ill_e(enc(7'h20, 5'd2, 5'd1, 3'b001, 5'd3, OP_IMM)));
    av(enc(7'h01, 5'd2, 5'd1, 3'b101, 5'd3, OP_IMM), ill_e(enc(7'h01, 5'd2, 5'd1, 3'b101, 5'd3, OP_IMM)));
    av(enc(7'h00, 5'd2, 5'd1, 3'b010, 5'd3, OP_BR),  ill_e(enc(7'h00, 5'd2, 5'd1, 3'b010, 5'd3, OP_BR)));
    av(enc(7'h00, 5'd2, 5'd1, 3'b011, 5'd3, OP_BR),  ill_e(enc(7'h00, 5'd2, 5'd1, 3'b011, 5'd3, OP_BR)));
    av(enc(7'h00, 5'd2, 5'd1, 3'b011, 5'd3, OP_LOAD), ill_e(enc(7'h00, 5'd2, 5'd1, 3'b011, 5'd3, OP_LOAD)));
    av(enc(7'h00, 5'd2, 5'd1, 3'b110, 5'd3, OP_LOAD), ill_e(enc(7'h00, 5'd2, 5'd1, 3'b110, 5'd3, OP_LOAD)));
    av(enc(7'h00, 5'd2, 5'd1, 3'b011, 5'd3, OP_STORE), ill_e(enc(7'h00, 5'd2, 5'd1, 3'b011, 5'd3, OP_STORE)));
    av(enc(7'h00, 5'd2, 5'd1, 3'b001, 5'd3, OP_JALR), ill_e(enc(7'h00, 5'd2, 5'd1, 3'b001, 5'd3, OP_JALR)));

    // Reset, with hold_i high so a missing reset gate on stall_o would show.
    rst = 1'b1; valid_i = 1'b1; instr_i = i_add3; flush_i = 1'b0; hold_i = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_bit("reset_stall", stall_o, 1'b0);
    sb.push_back(bubble());
    chk_ex("reset_ex");
    chk_cnt("reset_cnt", 0);
    rst = 1'b0; hold_i = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].instr, 1'b1, 1'b0, 1'b0, 1'b0, vecs[i].e, $sformatf("vec%0d", i));
      if (vecs[i].e.exp.illegal) cnt_m++;
    end
    chk_cnt("cnt_table", cnt_m);

    // Load-use via rs1, via rs2, unused rs field, and valid_i low.
    step(i_lw5, 1, 0, 0, 0, e_lw5, "lu_lw");
    step(i_add65, 1, 0, 0, 1, bubble(), "lu_bubble");
    step(i_add65, 1, 0, 0, 0, e_add65, "lu_add");
    step(i_lw5, 1, 0, 0, 0, e_lw5, "lu2_lw");
    step(i_add625, 1, 0, 0, 1, bubble(), "lu2_bubble");
    step(i_add625, 1, 0, 0, 0, mk(i_add625, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 4'd0, 0, 1, 4'b1111), "lu2_add");
    step(i_lw5, 1, 0, 0, 0, e_lw5, "lu3_lw");
    step(i_lui5, 1, 0, 0, 0, mk(i_lui5, 1, 2'b00, 0, 0, 0, 0, 0, 1, 0, 4'd11, 0, 1, 4'b0100), "lu3_lui");
    step(i_lw5, 1, 0, 0, 0, e_lw5, "lu4_lw");
    step(i_add65, 0, 0, 0, 0, bubble(), "lu4_novalid");

    step(i_lw0, 1, 0, 0, 0, mk(i_lw0, 1, 2'b01, 1, 0, 0, 0, 0, 1, 0, 4'd0, 0, 1, 4'b1110), "rd0_lw");
    step(i_add60, 1, 0, 0, 0, mk(i_add60, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 4'd0, 0, 1, 4'b1111), "rd0_add");

    step(i_lw5, 1, 0, 0, 0, e_lw5, "fl_lw");
    step(i_add65, 1, 1, 0, 0, bubble(), "fl_hazard");

    step(i_jal, 1, 0, 0, 0, mk(i_jal, 1, 2'b10, 0, 0, 0, 1, 0, 0, 0, 4'd0, 0, 0, 4'b0100), "jal");
    step(i_add3, 1, 1, 0, 0, bubble(), "jal_flush");
    step(i_add3, 1, 0, 0, 0, e_add3, "after_flush");

    step(i_sub7, 1, 0, 0, 0, e_sub7, "hold_sub");
    for (int k = 0; k < 3; k++) step(i_add3, 1, 0, 1, 1, e_sub7, $sformatf("hold%0d", k));
    step(i_add3, 1, 1, 1, 0, bubble(), "hold_flush");

    // Hazard appears under hold and is re-evaluated once hold drops.
    step(i_lw5, 1, 0, 0, 0, e_lw5, "hh_lw");
    step(i_add65, 1, 0, 1, 1, e_lw5, "hh_hold");
    step(i_add65, 1, 0, 0, 1, bubble(), "hh_bubble");
    step(i_add65, 1, 0, 0, 0, e_add65, "hh_add");

    step(i_ffff, 1, 0, 0, 0, ill_e(i_ffff), "ih_load");
    cnt_m++;
    step(i_ffff, 1, 0, 1, 1, ill_e(i_ffff), "ih_hold0");
    step(i_ffff, 1, 0, 1, 1, ill_e(i_ffff), "ih_hold1");
    chk_cnt("cnt_hold", cnt_m);
    step(i_ffff, 1, 1, 0, 0, bubble(), "ih_flush");
    chk_cnt("cnt_flush", cnt_m);

    // Saturation run from a cleared counter.
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cnt_m = 0;
    chk_cnt("sat_start", cnt_m);
    for (int k = 0; k < 300; k++) begin
      step(i_ffff, 1, 0, 0, 0, ill_e(i_ffff), $sformatf("sat%0d", k));
      cnt_m = (cnt_m == 255) ? 255 : cnt_m + 1;
      chk_cnt($sformatf("sat_cnt%0d", k), cnt_m);
    end
    chk_cnt("sat_final", 255);

    rst = 1'b1; hold_i = 1'b1; valid_i = 1'b1; instr_i = i_add3;
    #1;
    chk_bit("rst2_stall", stall_o, 1'b0);
    sb.push_back(bubble());
    @(posedge clk);
    @(negedge clk);
    chk_ex("rst2_ex");
    chk_cnt("rst2_cnt", 0);
    rst = 1'b0; hold_i = 1'b0; valid_i = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
